// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one ROM read port between IF and DM.
// DM has fixed priority; IF wins after MAX_WAIT consecutive denials.
// A grant at edge N produces a one-cycle valid pulse on the owner port in cycle N+2.
module rom_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_BLOCK  = 1024,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_valid,
    output logic [DATA_WIDTH-1:0] o_if_data,
    output logic                  o_if_oor,
    input  logic                  i_dm_req,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    output logic                  o_dm_gnt,
    output logic                  o_dm_valid,
    output logic [DATA_WIDTH-1:0] o_dm_data,
    output logic                  o_dm_oor,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT = ADDR_WIDTH'(ROM_BLOCK);
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_owner_q, s1_owner_d;
    logic                  s1_oor_q,   s1_oor_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]      starve_q,   starve_d;
    logic                  if_valid_q, if_valid_d;
    logic                  if_oor_q,   if_oor_d;
    logic [DATA_WIDTH-1:0] if_data_q,  if_data_d;
    logic                  dm_valid_q, dm_valid_d;
    logic                  dm_oor_q,   dm_oor_d;
    logic [DATA_WIDTH-1:0] dm_data_q,  dm_data_d;

    logic                  if_forced;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  unused_addr_bits;

    // Byte-offset bits play no part in word selection.
    assign unused_addr_bits = ^{i_if_addr[1:0], i_dm_addr[1:0]};

    // Combinational arbitration: DM first unless IF has been starved to the limit.
    always_comb begin
        if_forced = (starve_q == MAX_CNT);
        o_if_gnt  = !i_rst && i_if_req && (!i_dm_req || if_forced);
        o_dm_gnt  = !i_rst && i_dm_req && !(i_if_req && if_forced);
        sel_addr  = o_dm_gnt ? i_dm_addr : i_if_addr;
        word_idx  = {2'b00, sel_addr[ADDR_WIDTH-1:2]};
    end

    // Next-state: starvation counter, stage-1 capture and response stage.
    always_comb begin
        starve_d   = '0;
        s1_valid_d = 1'b0;
        s1_owner_d = s1_owner_q;
        s1_oor_d   = s1_oor_q;
        rom_addr_d = rom_addr_q;
        if_valid_d = 1'b0;
        if_oor_d   = 1'b0;
        if_data_d  = if_data_q;
        dm_valid_d = 1'b0;
        dm_oor_d   = 1'b0;
        dm_data_d  = dm_data_q;

        if (i_if_req && !o_if_gnt) begin
            starve_d = (starve_q == MAX_CNT) ? starve_q : starve_q + CNT_W'(1);
        end

        if (o_if_gnt || o_dm_gnt) begin
            rom_addr_d = word_idx;
            s1_valid_d = 1'b1;
            s1_owner_d = o_dm_gnt ? OWNER_DM : OWNER_IF;
            s1_oor_d   = (word_idx >= ROM_LIMIT);
        end

        if (s1_valid_q) begin
            if (s1_owner_q == OWNER_DM) begin
                dm_valid_d = 1'b1;
                dm_oor_d   = s1_oor_q;
                dm_data_d  = s1_oor_q ? '0 : i_rom_data;
            end else begin
                if_valid_d = 1'b1;
                if_oor_d   = s1_oor_q;
                if_data_d  = s1_oor_q ? '0 : i_rom_data;
            end
        end
    end

    // State registers; reset discards any in-flight read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_owner_q <= OWNER_IF;
            s1_oor_q   <= 1'b0;
            rom_addr_q <= '0;
            if_valid_q <= 1'b0;
            if_oor_q   <= 1'b0;
            if_data_q  <= '0;
            dm_valid_q <= 1'b0;
            dm_oor_q   <= 1'b0;
            dm_data_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            s1_oor_q   <= s1_oor_d;
            rom_addr_q <= rom_addr_d;
            if_valid_q <= if_valid_d;
            if_oor_q   <= if_oor_d;
            if_data_q  <= if_data_d;
            dm_valid_q <= dm_valid_d;
            dm_oor_q   <= dm_oor_d;
            dm_data_q  <= dm_data_d;
        end
    end

    assign o_rom_addr = rom_addr_q;
    assign o_busy     = s1_valid_q;
    assign o_if_valid = if_valid_q;
    assign o_if_oor   = if_oor_q;
    assign o_if_data  = if_data_q;
    assign o_dm_valid = dm_valid_q;
    assign o_dm_oor   = dm_oor_q;
    assign o_dm_data  = dm_data_q;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single-read-port instruction ROM between the fetch stage (IF) and the data-memory stage (DM, constant-table loads). It accepts word-aligned byte addresses from both requesters, grants one per cycle, drives the registered ROM word index, and returns the read word to the winning port with a fixed latency. It sits between the IF/MEM pipeline stages and the ROM instance. Fixed priority goes to DM, with a starvation guard for IF.

## Interface
- ADDR_WIDTH, 32, byte-address width of requester and ROM address buses
- DATA_WIDTH, 32, ROM word width
- ROM_BLOCK, 1024, number of ROM words; word index must be < ROM_BLOCK
- MAX_WAIT, 4, consecutive IF denials before IF is forced to win (1..15)

Ports:
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_if_req  in  1  IF read request; level, held with address until granted
- i_if_addr  in  ADDR_WIDTH  IF byte address
- o_if_gnt  out  1  combinational; request accepted at this edge
- o_if_valid  out  1  one-cycle pulse; o_if_data holds the response
- o_if_data  out  DATA_WIDTH  IF response word
- o_if_oor  out  1  qualifies o_if_valid; address was out of range
- i_dm_req, i_dm_addr, o_dm_gnt, o_dm_valid, o_dm_data, o_dm_oor: same as the IF ports, for DM
- o_rom_addr  out  ADDR_WIDTH  registered word index to the ROM
- i_rom_data  in  DATA_WIDTH  combinational ROM output for o_rom_addr
- o_busy  out  1  a stage-1 read is in flight

## Operation
- Word index = addr[ADDR_WIDTH-1:2], zero-extended to ADDR_WIDTH; addr[1:0] is ignored.
- Arbitration (combinational, every cycle):
  - Only one request: that request is granted.
  - Both requests: DM is granted, unless starve_cnt == MAX_WAIT, in which case IF is granted.
  - At most one gnt is high per cycle.
- starve_cnt, width 4:
  - Increments, saturating at MAX_WAIT, on edges where i_if_req=1 and o_if_gnt=0.
  - Clears on an IF grant, or when i_if_req=0.
- Pipeline, no stall:
  - Accept edge (req & gnt): o_rom_addr <= word index; s1_valid <= 1; s1_owner <= winner; s1_oor <= (index >= ROM_BLOCK).
  - With no grant: s1_valid <= 0 and o_rom_addr holds its value.
- Response edge, when s1_valid=1:
  - Owner's data <= (s1_oor ? 0 : i_rom_data).
  - Owner's valid <= 1 for exactly one cycle.
  - Owner's oor <= s1_oor.
  - The other port's valid <= 0.
- Data registers hold their last value between pulses. oor is meaningful only while valid=1, and clears with valid.
- o_busy = s1_valid.
- Reset (asynchronous, any time, including mid-flight):
  - Zero: all valid, oor, and data outputs; o_rom_addr; s1_valid; s1_owner (IF); starve_cnt.
  - The in-flight response is discarded and never delivered.
  - gnt outputs are forced to 0 while i_rst=1.

## Timing
- Latency: request granted in cycle N → valid high in cycle N+2, for 1 cycle.
- Throughput: one accept per cycle; back-to-back grants yield back-to-back valids, in grant order.
- A requester must hold req and addr stable until it sees gnt. Deasserting req before gnt is legal and simply withdraws the request.
- ROM read path: o_rom_addr register → ROM → i_rom_data → response register. This is one full cycle of combinational ROM access.
- Out-of-range reads still take the same 2-cycle latency.

## Test plan
- Reset then single IF read: i_if_addr=0x0000_0008 with mem[2]=0xDEADBEEF → o_if_gnt in cycle 0, o_rom_addr=2 after the edge, o_if_valid=1 in cycle 2 with o_if_data=0xDEADBEEF, o_if_oor=0.
- Simultaneous requests, IF addr 0x4 and DM addr 0x10 → DM granted first, IF next cycle. o_dm_valid in cycle 2 with mem[4]; o_if_valid in cycle 3 with mem[1]. The two valids are never high together.
- Starvation: both requests held continuously, MAX_WAIT=4 → grant sequence DM,DM,DM,DM,IF,DM,… with starve_cnt saturating at 4, then clearing on the IF grant.
- Out of range: i_dm_addr=0x0000_1000 (index 1024) → o_dm_valid in cycle 2 with o_dm_data=0 and o_dm_oor=1. Also check that index 1023 returns mem[1023] with oor=0.
- Reset mid-flight: assert i_rst asynchronously one cycle after an IF grant → o_if_valid never pulses, all outputs read 0 immediately, and no response appears after reset release.
- Streaming: IF requests 8 consecutive cycles to addresses 0x0..0x1C → 8 consecutive valid cycles returning mem[0..7] in order, and o_busy stays high throughout.
